bp_stream_io_master: RTL and testbench

Host-to-BlackParrot stream bridge: deserializes 32-bit stream packets from the host link into uncached I/O commands on the BP memory-message interface and serializes read-response data back onto the outbound stream. It sits at the FPGA host edge, on the opposite direction of the BP-to-host MMIO stream path, so the host can initiate loads and stores into the BP address space.

---
 rtl/bp_stream_io_master_pkg.sv | 74 +++++++
 rtl/bp_stream_io_master_piso.sv | 41 ++++
 rtl/bp_stream_io_master.sv | 147 ++++++++++++++
 tb/tb_bp_stream_io_master.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_stream_io_master_pkg.sv
// Shared definitions for the host stream <-> BlackParrot I/O bridge: memory message
// layout, message types and the stream packet op-word encoding used in both directions.
package bp_stream_io_master_pkg;

    localparam int paddr_width_p        = 40;
    localparam int dword_width_p        = 64;
    localparam int stream_word_width_lp = dword_width_p / 2;

    typedef enum logic [3:0] {
        e_cce_mem_rd    = 4'd0,
        e_cce_mem_wr    = 4'd1,
        e_cce_mem_uc_rd = 4'd2,
        e_cce_mem_uc_wr = 4'd3,
        e_cce_mem_pre   = 4'd4
    } bp_cce_mem_msg_type_e;

    typedef struct packed {
        bp_cce_mem_msg_type_e        msg_type;
        logic [3:0]                  subop;
        logic [paddr_width_p-1:0]    addr;
        logic [2:0]                  size;
        logic [15:0]                 payload;
    } bp_cce_mem_msg_header_s;

    typedef struct packed {
        bp_cce_mem_msg_header_s      header;
        logic [dword_width_p-1:0]    data;
    } bp_cce_mem_msg_s;

    localparam int cce_mem_msg_width_lp = $bits(bp_cce_mem_msg_s);

    // Op word: [0] write, [2:1] log2 of access size in bytes, upper bits ignored
    localparam int stream_op_write_bit_lp = 0;
    localparam int stream_op_size_lsb_lp  = 1;

    typedef enum logic [1:0] {
        e_stream_size_1b = 2'd0,
        e_stream_size_2b = 2'd1,
        e_stream_size_4b = 2'd2,
        e_stream_size_8b = 2'd3
    } bp_stream_size_e;

    localparam int stream_rd_words_lp    = 2;
    localparam int stream_wr_words_lp    = 3;
    localparam int stream_wr8_words_lp   = 4;

    function automatic int stream_pkt_words(input logic write, input logic [1:0] size);
        if (!write)                   return stream_rd_words_lp;
        else if (size == e_stream_size_8b) return stream_wr8_words_lp;
        else                          return stream_wr_words_lp;
    endfunction

    // Only the 8-byte write carries a high data word; narrower writes keep it zero.
    function automatic bp_cce_mem_msg_s stream_pkt_to_cmd(
        input logic                            write,
        input logic [1:0]                      size,
        input logic [stream_word_width_lp-1:0] addr,
        input logic [stream_word_width_lp-1:0] data_lo,
        input logic [stream_word_width_lp-1:0] data_hi
    );
        bp_cce_mem_msg_s msg;
        msg                 = '0;
        msg.header.msg_type = write ? e_cce_mem_uc_wr : e_cce_mem_uc_rd;
        msg.header.addr     = {{(paddr_width_p-stream_word_width_lp){1'b0}}, addr};
        msg.header.size     = {1'b0, size};
        if (write) begin
            msg.data[stream_word_width_lp-1:0] = data_lo;
            if (size == e_stream_size_8b)
                msg.data[dword_width_p-1:stream_word_width_lp] = data_hi;
        end
        return msg;
    endfunction

endpackage

// File: rtl/bp_stream_io_master_piso.sv
// Two-word parallel-in/serial-out buffer: accepts a double word, emits low word then high word.
module bp_stream_piso_async #(
    parameter int width_p = 32
) (
    input  logic                 clk_i,
    input  logic                 reset_n_i,
    input  logic                 v_i,
    input  logic [2*width_p-1:0] data_i,
    output logic                 ready_o,
    output logic                 v_o,
    output logic [width_p-1:0]   data_o,
    input  logic                 yumi_i
);

    logic [1:0]           words_left_r;
    logic [2*width_p-1:0] data_r;
    logic                 load;

    // Refill in the same cycle the last word leaves so back-to-back loads have no bubble
    assign ready_o = (words_left_r == 2'd0) | ((words_left_r == 2'd1) & yumi_i);
    assign load    = v_i & ready_o;
    assign v_o     = (words_left_r != 2'd0);
    assign data_o  = (words_left_r == 2'd2) ? data_r[width_p-1:0]
                                            : data_r[2*width_p-1:width_p];

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            words_left_r <= 2'd0;
        end else if (load) begin
            words_left_r <= 2'd2;
        end else if (yumi_i & v_o) begin
            words_left_r <= words_left_r - 2'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (load)
            data_r <= data_i;
    end

endmodule

// File: rtl/bp_stream_io_master.sv
// Host-to-BlackParrot stream bridge: turns inbound stream packets into uncached I/O
// commands and serializes read-response data back onto the outbound stream.
module bp_stream_io_master
    import bp_stream_io_master_pkg::*;
#(
    parameter int stream_data_width_p = 32,
    parameter int max_outstanding_p   = 4
) (
    input  logic                            clk_i,
    input  logic                            reset_n_i,

    input  logic                            stream_v_i,
    input  logic [stream_data_width_p-1:0]  stream_data_i,
    output logic                            stream_ready_o,

    output logic [cce_mem_msg_width_lp-1:0] io_cmd_o,
    output logic                            io_cmd_v_o,
    input  logic                            io_cmd_ready_i,

    input  logic [cce_mem_msg_width_lp-1:0] io_resp_i,
    input  logic                            io_resp_v_i,
    output logic                            io_resp_yumi_o,

    output logic                            stream_v_o,
    output logic [stream_data_width_p-1:0]  stream_data_o,
    input  logic                            stream_yumi_i
);

    localparam int cnt_width_lp = $clog2(max_outstanding_p + 1);
    localparam logic [cnt_width_lp-1:0] max_outstanding_lp = cnt_width_lp'(max_outstanding_p);

    localparam logic [2:0] e_op      = 3'd0;
    localparam logic [2:0] e_addr    = 3'd1;
    localparam logic [2:0] e_data_lo = 3'd2;
    localparam logic [2:0] e_data_hi = 3'd3;
    localparam logic [2:0] e_send    = 3'd4;

    logic [2:0]                     state_r;
    logic                           op_write_r;
    logic [1:0]                     op_size_r;
    logic [stream_data_width_p-1:0] addr_r;
    logic [stream_data_width_p-1:0] data_lo_r;
    bp_cce_mem_msg_s                cmd_r;
    logic [cnt_width_lp-1:0]        outstanding_r;

    logic in_hs;
    logic cmd_hs;
    logic resp_dec;

    // Ready is forced low while reset is held even though the FSM already sits in e_op
    assign stream_ready_o = reset_n_i & (state_r != e_send);
    assign in_hs          = stream_v_i & stream_ready_o;

    assign io_cmd_v_o = (state_r == e_send) & (outstanding_r < max_outstanding_lp);
    assign io_cmd_o   = cmd_r;
    assign cmd_hs     = io_cmd_v_o & io_cmd_ready_i;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r    <= e_op;
            op_write_r <= 1'b0;
            op_size_r  <= 2'd0;
        end else begin
            case (state_r)
                e_op: if (in_hs) begin
                    op_write_r <= stream_data_i[stream_op_write_bit_lp];
                    op_size_r  <= stream_data_i[stream_op_size_lsb_lp +: 2];
                    state_r    <= e_addr;
                end
                e_addr: if (in_hs) begin
                    state_r <= op_write_r ? e_data_lo : e_send;
                end
                e_data_lo: if (in_hs) begin
                    state_r <= (op_size_r == e_stream_size_8b) ? e_data_hi : e_send;
                end
                e_data_hi: if (in_hs) begin
                    state_r <= e_send;
                end
                e_send: if (cmd_hs) begin
                    state_r <= e_op;
                end
                default: state_r <= e_op;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (in_hs && state_r == e_addr)
            addr_r <= stream_data_i;
        if (in_hs && state_r == e_data_lo)
            data_lo_r <= stream_data_i;
    end

    // Command is rebuilt on every body word; the last one before e_send is the one held stable
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            cmd_r <= '0;
        end else if (in_hs) begin
            case (state_r)
                e_addr:    cmd_r <= stream_pkt_to_cmd(op_write_r, op_size_r, stream_data_i, '0, '0);
                e_data_lo: cmd_r <= stream_pkt_to_cmd(op_write_r, op_size_r, addr_r, stream_data_i, '0);
                e_data_hi: cmd_r <= stream_pkt_to_cmd(op_write_r, op_size_r, addr_r, data_lo_r, stream_data_i);
                default:   cmd_r <= cmd_r;
            endcase
        end
    end

    bp_cce_mem_msg_s resp_cast;
    logic            resp_is_wr;
    logic            piso_ready;
    logic            unused_resp_hdr;

    assign resp_cast       = io_resp_i;
    assign resp_is_wr      = (resp_cast.header.msg_type == e_cce_mem_uc_wr);
    assign unused_resp_hdr = ^{resp_cast.header.subop, resp_cast.header.addr,
                               resp_cast.header.size, resp_cast.header.payload};

    // Write acks never touch the serializer; everything else is treated as read data
    assign io_resp_yumi_o = reset_n_i & io_resp_v_i & (resp_is_wr | piso_ready);

    // A response arriving with nothing outstanding is a protocol error; hold the count at zero
    assign resp_dec = io_resp_yumi_o & (outstanding_r != '0);

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            outstanding_r <= '0;
        end else if (cmd_hs & ~resp_dec) begin
            outstanding_r <= outstanding_r + cnt_width_lp'(1);
        end else if (~cmd_hs & resp_dec) begin
            outstanding_r <= outstanding_r - cnt_width_lp'(1);
        end
    end

    bp_stream_piso_async #(
        .width_p (stream_data_width_p)
    ) resp_piso (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .v_i       (reset_n_i & io_resp_v_i & ~resp_is_wr),
        .data_i    (resp_cast.data),
        .ready_o   (piso_ready),
        .v_o       (stream_v_o),
        .data_o    (stream_data_o),
        .yumi_i    (stream_yumi_i)
    );

endmodule

// File: tb/tb_bp_stream_io_master.sv
// Randomized bench for bp_stream_io_master with a queue-based reference model.
module tb_bp_stream_io_master;
    import bp_stream_io_master_pkg::*;

    localparam int W    = 32;
    localparam int MAXO = 4;
    localparam int MW   = cce_mem_msg_width_lp;

    logic          clk_i = 1'b0;
    logic          reset_n_i = 1'b1;
    logic          stream_v_i = 1'b0;
    logic [W-1:0]  stream_data_i = '0;
    logic          stream_ready_o;
    logic [MW-1:0] io_cmd_o;
    logic          io_cmd_v_o;
    logic          io_cmd_ready_i = 1'b0;
    logic [MW-1:0] io_resp_i = '0;
    logic          io_resp_v_i = 1'b0;
    logic          io_resp_yumi_o;
    logic          stream_v_o;
    logic [W-1:0]  stream_data_o;
    logic          stream_yumi_i = 1'b0;

    always #5 clk_i = ~clk_i;

    bp_stream_io_master #(
        .stream_data_width_p (W),
        .max_outstanding_p   (MAXO)
    ) dut (
        .clk_i          (clk_i),
        .reset_n_i      (reset_n_i),
        .stream_v_i     (stream_v_i),
        .stream_data_i  (stream_data_i),
        .stream_ready_o (stream_ready_o),
        .io_cmd_o       (io_cmd_o),
        .io_cmd_v_o     (io_cmd_v_o),
        .io_cmd_ready_i (io_cmd_ready_i),
        .io_resp_i      (io_resp_i),
        .io_resp_v_i    (io_resp_v_i),
        .io_resp_yumi_o (io_resp_yumi_o),
        .stream_v_o     (stream_v_o),
        .stream_data_o  (stream_data_o),
        .stream_yumi_i  (stream_yumi_i)
    );

    int checks = 0;
    int errors = 0;
    int p_in = 100, p_cmd = 100, p_resp = 100, p_yumi = 100;
    bit resp_en = 1'b1;

    logic [31:0]     tx_q[$];
    logic [31:0]     cur[$];
    bp_cce_mem_msg_s exp_cmd[$];
    bp_cce_mem_msg_s inflight[$];
    bp_cce_mem_msg_s obs_cmd[$];
    logic [31:0]     exp_out[$];
    logic [31:0]     obs_out[$];
    logic [63:0]     rd_data_q[$];
    bit              resp_active = 1'b0;
    bp_cce_mem_msg_s resp_msg = '0;

    task automatic chk(input string name, input logic [MW-1:0] act, input logic [MW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Packet decode straight from the word-count and op-field rules
    task automatic model_word(input logic [31:0] w);
        logic [31:0]     op;
        int              need;
        bp_cce_mem_msg_s m;
        cur.push_back(w);
        op   = cur[0];
        need = (op[0] == 1'b0) ? 2 : ((op[2:1] == 2'd3) ? 4 : 3);
        if (cur.size() == need) begin
            m                 = '0;
            m.header.addr     = {{(paddr_width_p-32){1'b0}}, cur[1]};
            m.header.size     = {1'b0, op[2:1]};
            m.header.msg_type = op[0] ? e_cce_mem_uc_wr : e_cce_mem_uc_rd;
            if (op[0]) begin
                m.data[31:0] = cur[2];
                if (need == 4) m.data[63:32] = cur[3];
            end
            exp_cmd.push_back(m);
            cur.delete();
        end
    endtask

    task automatic model_reset();
        tx_q.delete(); cur.delete(); exp_cmd.delete(); inflight.delete();
        exp_out.delete(); rd_data_q.delete();
        resp_active = 1'b0;
    endtask

    function automatic bit idle();
        return tx_q.size() == 0 && cur.size() == 0 && exp_cmd.size() == 0 &&
               inflight.size() == 0 && exp_out.size() == 0 && !resp_active;
    endfunction

    task automatic gen_packet();
        logic [31:0] op;
        logic        wr;
        logic [1:0]  sz;
        wr = 1'($urandom_range(1));
        sz = 2'($urandom_range(3));
        op = $urandom;
        op[2:0] = {sz, wr};
        tx_q.push_back(op);
        tx_q.push_back($urandom);
        if (wr) begin
            tx_q.push_back($urandom);
            if (sz == 2'd3) tx_q.push_back($urandom);
        end
    endtask

    task automatic step();
        bit exp_ready, exp_cv, exp_yumi, is_wr;
        @(negedge clk_i);
        if (tx_q.size() > 0 && $urandom_range(99) < p_in) begin
            stream_v_i    = 1'b1;
            stream_data_i = tx_q[0];
        end else begin
            stream_v_i    = 1'b0;
            stream_data_i = $urandom;
        end
        io_cmd_ready_i = ($urandom_range(99) < p_cmd);
        if (!resp_active && resp_en && inflight.size() > 0 && $urandom_range(99) < p_resp) begin
            resp_msg                = inflight[0];
            resp_msg.header.payload = 16'($urandom);
            resp_msg.data           = {$urandom, $urandom};
            if (inflight[0].header.msg_type != e_cce_mem_uc_wr && rd_data_q.size() > 0)
                resp_msg.data = rd_data_q.pop_front();
            resp_active = 1'b1;
        end
        io_resp_v_i   = resp_active;
        io_resp_i     = resp_msg;
        stream_yumi_i = stream_v_o && ($urandom_range(99) < p_yumi);
        #1;
        exp_ready = (exp_cmd.size() == 0);
        exp_cv    = (exp_cmd.size() > 0) && (inflight.size() < MAXO);
        is_wr     = resp_active && (resp_msg.header.msg_type == e_cce_mem_uc_wr);
        exp_yumi  = resp_active && (is_wr || exp_out.size() == 0 ||
                                    (exp_out.size() == 1 && stream_yumi_i));
        chk("stream_ready_o", MW'(stream_ready_o), MW'(exp_ready));
        chk("io_cmd_v_o", MW'(io_cmd_v_o), MW'(exp_cv));
        if (io_cmd_v_o && exp_cmd.size() > 0) chk("io_cmd_o", io_cmd_o, exp_cmd[0]);
        chk("io_resp_yumi_o", MW'(io_resp_yumi_o), MW'(exp_yumi));
        chk("stream_v_o", MW'(stream_v_o), MW'(exp_out.size() > 0));
        if (stream_v_o && exp_out.size() > 0) chk("stream_data_o", MW'(stream_data_o), MW'(exp_out[0]));

        if (stream_v_o && stream_yumi_i) obs_out.push_back(stream_data_o);
        if (exp_out.size() > 0 && stream_yumi_i) void'(exp_out.pop_front());
        if (exp_yumi) begin
            void'(inflight.pop_front());
            if (!is_wr) begin
                exp_out.push_back(resp_msg.data[31:0]);
                exp_out.push_back(resp_msg.data[63:32]);
            end
            resp_active = 1'b0;
        end
        if (io_cmd_v_o && io_cmd_ready_i) obs_cmd.push_back(io_cmd_o);
        if (exp_cv && io_cmd_ready_i) inflight.push_back(exp_cmd.pop_front());
        if (stream_v_i && exp_ready) model_word(tx_q.pop_front());
    endtask

    task automatic do_reset(input int cycles);
        @(negedge clk_i);
        reset_n_i = 1'b0;
        stream_v_i = 1'b0; io_resp_v_i = 1'b0; stream_yumi_i = 1'b0; io_cmd_ready_i = 1'b0;
        model_reset();
        for (int i = 0; i < cycles; i++) begin
            #1;
            chk("rst_stream_ready_o", MW'(stream_ready_o), '0);
            chk("rst_io_cmd_v_o", MW'(io_cmd_v_o), '0);
            chk("rst_io_cmd_o", io_cmd_o, '0);
            chk("rst_io_resp_yumi_o", MW'(io_resp_yumi_o), '0);
            chk("rst_stream_v_o", MW'(stream_v_o), '0);
            @(negedge clk_i);
        end
        reset_n_i = 1'b1;
        #1;
        chk("ready_after_reset", MW'(stream_ready_o), MW'(1));
    endtask

    task automatic drain(input int budget, input string name);
        for (int i = 0; i < budget && !idle(); i++) step();
        chk(name, MW'(idle()), MW'(1));
    endtask

    initial begin
        int base, obase;
        do_reset(2);

        // Read example: 4-byte uncached read, response split low word first
        base = obs_cmd.size(); obase = obs_out.size();
        rd_data_q.push_back(64'h1122_3344_5566_7788);
        tx_q.push_back(32'h4); tx_q.push_back(32'h0010_0000);
        drain(60, "drain_read");
        chk("rd_cmd_count", MW'(obs_cmd.size()), MW'(base + 1));
        chk("rd_out_count", MW'(obs_out.size()), MW'(obase + 2));
        if (obs_cmd.size() > base) begin
            chk("rd_msg_type", MW'(obs_cmd[base].header.msg_type), MW'(4'd2));
            chk("rd_addr", MW'(obs_cmd[base].header.addr), MW'(40'h10_0000));
            chk("rd_size", MW'(obs_cmd[base].header.size), MW'(3'd2));
            chk("rd_data_zero", MW'(obs_cmd[base].data), '0);
        end
        if (obs_out.size() >= obase + 2) begin
            chk("rd_word_lo", MW'(obs_out[obase]), MW'(32'h5566_7788));
            chk("rd_word_hi", MW'(obs_out[obase+1]), MW'(32'h1122_3344));
        end

        // 8-byte write: data assembled hi:lo, write ack produces no stream word
        base = obs_cmd.size(); obase = obs_out.size();
        tx_q.push_back(32'h7); tx_q.push_back(32'h200);
        tx_q.push_back(32'hDEAD_BEEF); tx_q.push_back(32'hCAFE_F00D);
        drain(60, "drain_write");
        for (int i = 0; i < 5; i++) step();
        chk("wr_no_stream", MW'(obs_out.size()), MW'(obase));
        if (obs_cmd.size() > base) begin
            chk("wr_msg_type", MW'(obs_cmd[base].header.msg_type), MW'(4'd3));
            chk("wr_size", MW'(obs_cmd[base].header.size), MW'(3'd3));
            chk("wr_addr", MW'(obs_cmd[base].header.addr), MW'(40'h200));
            chk("wr_data", MW'(obs_cmd[base].data), MW'(64'hCAFE_F00D_DEAD_BEEF));
        end else chk("wr_cmd_count", MW'(obs_cmd.size()), MW'(base + 1));

        // Credit limit: five reads, no responses -> only four issued
        base = obs_cmd.size();
        resp_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tx_q.push_back(32'h4); tx_q.push_back(32'h1000 + 32'(i) * 32'h8);
        end
        for (int i = 0; i < 60; i++) step();
        chk("credit_issued", MW'(obs_cmd.size() - base), MW'(4));
        chk("credit_cmd_v_low", MW'(io_cmd_v_o), '0);
        chk("credit_ready_low", MW'(stream_ready_o), '0);
        resp_en = 1'b1;
        drain(200, "drain_credit");
        chk("credit_total", MW'(obs_cmd.size() - base), MW'(5));

        // Command backpressure: held ten cycles, command compared every cycle
        p_cmd = 0;
        tx_q.push_back(32'h2); tx_q.push_back(32'h40);
        for (int i = 0; i < 14; i++) step();
        chk("bp_cmd_v_high", MW'(io_cmd_v_o), MW'(1));
        chk("bp_ready_low", MW'(stream_ready_o), '0);
        p_cmd = 100;
        drain(60, "drain_cmd_bp");

        // Outbound backpressure: second read response waits for the serializer
        obase = obs_out.size();
        p_yumi = 0;
        tx_q.push_back(32'h4); tx_q.push_back(32'h80);
        tx_q.push_back(32'h6); tx_q.push_back(32'h88);
        for (int i = 0; i < 30; i++) step();
        chk("ser_resp_waiting", MW'(io_resp_v_i), MW'(1));
        chk("ser_resp_not_yumi", MW'(io_resp_yumi_o), '0);
        chk("ser_no_words_out", MW'(obs_out.size()), MW'(obase));
        p_yumi = 100;
        drain(60, "drain_ser_bp");
        chk("ser_words_out", MW'(obs_out.size()), MW'(obase + 4));

        // Reset after word1 of a write discards it; next packet decodes cleanly
        tx_q.push_back(32'h7); tx_q.push_back(32'h500);
        for (int i = 0; i < 20 && cur.size() < 2; i++) step();
        chk("partial_pkt_taken", MW'(cur.size()), MW'(2));
        do_reset(2);
        base = obs_cmd.size();
        tx_q.push_back(32'h0); tx_q.push_back(32'h3000);
        drain(60, "drain_after_reset");
        chk("post_reset_cmds", MW'(obs_cmd.size()), MW'(base + 1));
        if (obs_cmd.size() > base) begin
            chk("post_reset_type", MW'(obs_cmd[base].header.msg_type), MW'(4'd2));
            chk("post_reset_addr", MW'(obs_cmd[base].header.addr), MW'(40'h3000));
            chk("post_reset_size", MW'(obs_cmd[base].header.size), '0);
        end

        // Random traffic with shifting handshake probabilities
        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0) begin
                p_in   = $urandom_range(30, 100);
                p_cmd  = $urandom_range(20, 100);
                p_resp = $urandom_range(5, 100);
                p_yumi = $urandom_range(20, 100);
            end
            if (tx_q.size() == 0 && $urandom_range(99) < 50) gen_packet();
            step();
        end
        p_in = 100; p_cmd = 100; p_resp = 100; p_yumi = 100;
        drain(400, "drain_final");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
